// File: rtl/fb_writer_pkg.sv
// fb_writer_pkg
// Shared definitions for the frame-buffer pixel writer:
//   PIX_W / WORD_W : packed 6:6:6 pixel width and two-pixel ZBT word width
//   ENTRY_ADDR_W   : address width carried in a word FIFO entry
//   fifo_entry_t   : one queued write, {addr, data}
//   wr_state_t     : write FSM states IDLE / REQ / WRITE
package fb_writer_pkg;

    localparam int PIX_W        = 18;
    localparam int WORD_W       = 36;
    // Width of the address field stored in the FIFO. The top level's ADDR_W
    // parameter defaults to this value; the top casts between the two.
    localparam int ENTRY_ADDR_W = 19;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]       data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2
    } wr_state_t;

endpackage

// File: rtl/fb_word_fifo.sv
// fb_word_fifo
// Small synchronous FIFO holding packed frame-buffer writes.
// Ports:
//   clk, reset : clock and synchronous active-high reset (empties the FIFO)
//   push       : write push_data this cycle; ignored when full unless pop
//                is also asserted (the entry being popped frees its slot)
//   push_data  : entry to enqueue
//   pop        : remove the head entry this cycle (never asserted when empty)
//   head       : current head entry, visible combinationally
//   full/empty : occupancy flags for the current cycle
// Pointers count entries with one spare bit so full and empty are
// distinguished without a separate counter.
module fb_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 55
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push while full succeeds only when the head leaves in the same cycle.
    // The write then lands in the slot being vacated, which is safe because
    // the head is read combinationally before the edge.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
// Writes the processed pixel stream into the frame buffer.
// The source valid/start-of-frame strobes are delayed to line up with the
// colour pipeline output, each pixel is truncated to 6:6:6, two pixels are
// packed into one 36-bit word, and words are queued in a small FIFO that is
// drained through a request/grant port shared with the display reader.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   uptRGB     : processed pixel {R,G,B}, valid when the delayed valid is high
//   pix_valid  : pixel valid, aligned with RGB entering the colour stage
//   pix_sof    : first pixel of a frame, qualified by pix_valid
//   mem_req    : frame-buffer access request (held from REQ through WRITE)
//   mem_grant  : arbiter grant, honoured only in REQ
//   mem_we     : one-cycle write strobe
//   mem_addr   : write address, holds its last value outside WRITE
//   mem_data   : write data, holds its last value outside WRITE
//   overflow   : sticky, set when a completed word could not be queued
//
// Handshake: a write is requested by holding mem_req high; the arbiter
// answers with mem_grant while the FSM is in REQ, the head word is loaded
// into mem_addr/mem_data on that edge and mem_we pulses for exactly the next
// cycle. mem_req only falls after a WRITE cycle with nothing left to send.
module fb_pixel_writer #(
    parameter int PIPE_LAT    = 8,
    parameter int FRAME_WORDS = 153600,
    parameter int ADDR_W      = 19,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [23:0]       uptRGB,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic              mem_req,
    input  logic              mem_grant,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [35:0]       mem_data,
    output logic              overflow
);

    import fb_writer_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    // ------------------------------------------------------------------
    // Strobe delay lines: d_valid/d_sof line up with uptRGB.
    // ------------------------------------------------------------------
    logic [PIPE_LAT-1:0] valid_sr;
    logic [PIPE_LAT-1:0] sof_sr;
    logic                d_valid;
    logic                d_sof;

    assign d_valid = valid_sr[PIPE_LAT-1];
    assign d_sof   = sof_sr[PIPE_LAT-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_sr <= '0;
            sof_sr   <= '0;
        end else begin
            valid_sr <= {valid_sr[PIPE_LAT-2:0], pix_valid};
            sof_sr   <= {sof_sr[PIPE_LAT-2:0], pix_sof};
        end
    end

    // ------------------------------------------------------------------
    // Truncation to 6:6:6.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] pix;
    logic             unused_lsbs;

    assign pix         = {uptRGB[23:18], uptRGB[15:10], uptRGB[7:2]};
    assign unused_lsbs = ^{uptRGB[17:16], uptRGB[9:8], uptRGB[1:0]};

    // ------------------------------------------------------------------
    // Packer and address counter.
    // hold_sof marks that the held first half started a frame; the word it
    // completes goes to address 0 and restarts the counter after it.
    // ------------------------------------------------------------------
    logic              half;
    logic              hold_sof;
    logic [PIX_W-1:0]  hold;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] word_addr;
    logic              push;
    fifo_entry_t       push_entry;

    // An SOF pixel always starts a new word, so it never completes one.
    assign push      = d_valid && half && !d_sof;
    assign word_addr = hold_sof ? '0 : wr_addr;

    always_comb begin
        push_entry      = '0;
        push_entry.addr = ENTRY_ADDR_W'(word_addr);
        push_entry.data = {hold, pix};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            half     <= 1'b0;
            hold_sof <= 1'b0;
            hold     <= '0;
            wr_addr  <= '0;
        end else if (d_valid) begin
            if (d_sof || !half) begin
                // First half of a word; a pending half is discarded on SOF.
                hold     <= pix;
                hold_sof <= d_sof;
                half     <= 1'b1;
            end else begin
                // Word completed: the address advances even if the FIFO
                // drops it, so later words keep their frame position.
                half     <= 1'b0;
                hold_sof <= 1'b0;
                if (word_addr == LAST_ADDR) begin
                    wr_addr <= '0;
                end else begin
                    wr_addr <= word_addr + ADDR_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO.
    // ------------------------------------------------------------------
    wr_state_t   state;
    fifo_entry_t head_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    // REQ is only entered with a non-empty FIFO and nothing else pops, so a
    // grant in REQ always has a head to take.
    assign pop = (state == REQ) && mem_grant;

    fb_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fifo_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write FSM with registered request/strobe/address/data outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mem_we <= 1'b0;
                    if (!fifo_empty) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_grant) begin
                        state    <= WRITE;
                        mem_we   <= 1'b1;
                        mem_addr <= ADDR_W'(head_entry.addr);
                        mem_data <= head_entry.data;
                    end
                end
                WRITE: begin
                    mem_we <= 1'b0;
                    if (!fifo_empty) begin
                        state <= REQ;
                    end else begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Testbench for fb_pixel_writer with FRAME_WORDS=4 so address wrap is
// reachable in a short run.
module tb_fb_pixel_writer;

    localparam int PIPE_LAT    = 8;
    localparam int FRAME_WORDS = 4;
    localparam int ADDR_W      = 19;
    localparam int FIFO_DEPTH  = 4;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic [23:0]       uptRGB;
    logic              pix_valid;
    logic              pix_sof;
    logic              mem_req;
    logic              mem_grant;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [35:0]       mem_data;
    logic              overflow;

    always #5 clk = ~clk;

    fb_pixel_writer #(
        .PIPE_LAT    (PIPE_LAT),
        .FRAME_WORDS (FRAME_WORDS),
        .ADDR_W      (ADDR_W),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uptRGB    (uptRGB),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .mem_req   (mem_req),
        .mem_grant (mem_grant),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .overflow  (overflow)
    );

    // Colour-stage stand-in: the pixel driven with pix_valid reappears on
    // uptRGB PIPE_LAT cycles later.
    logic [23:0] rgb_in;
    logic [23:0] rgb_line [PIPE_LAT];

    always @(posedge clk) begin
        rgb_line[0] <= rgb_in;
        for (int i = 1; i < PIPE_LAT; i++) rgb_line[i] <= rgb_line[i-1];
    end
    assign uptRGB = rgb_line[PIPE_LAT-1];

    // ---------------- scoreboard ----------------
    int passed = 0;
    int total  = 0;
    logic [54:0] exp_q[$];
    logic [54:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            check("we_with_req", 64'(mem_req), 64'd1);
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL spurious_write: got addr=%h data=%h expected no write", mem_addr, mem_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(mon_e[54:36]));
                check("wr_data", 64'(mem_data), 64'(mon_e[35:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic s, input logic [23:0] rgb);
        pix_valid = v;
        pix_sof   = s;
        rgb_in    = rgb;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_grant = 1'b0;
        drive(1'b0, 1'b0, 24'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            next_cycle();
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (10) next_cycle();
    endtask

    // Grey pixel whose 6-bit channels all equal j (j < 64).
    function automatic logic [23:0] gray(input int j);
        logic [7:0] b;
        b = 8'(4 * j);
        return {b, b, b};
    endfunction

    // Word packed from grey pixels j and j+1.
    function automatic logic [35:0] gword(input int j);
        logic [5:0] a;
        logic [5:0] c;
        a = 6'(j);
        c = 6'(j + 1);
        return {a, a, a, c, c, c};
    endfunction

    typedef struct {
        logic [23:0] rgb_a;
        logic [23:0] rgb_b;
        logic        sof;
        logic [18:0] exp_addr;
        logic [35:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        vecs[0] = '{24'hFFFFFF, 24'h040404, 1'b1, 19'd0, 36'hFFFFC1041};
        vecs[1] = '{24'h000000, 24'hFFFFFF, 1'b0, 19'd1, 36'h00003FFFF};
        vecs[2] = '{24'h123456, 24'hABCDEF, 1'b0, 19'd2, 36'h10D56ACFB};
        vecs[3] = '{24'h800000, 24'h00FF03, 1'b0, 19'd3, 36'h800000FC0};
        vecs[4] = '{24'h0C0C0C, 24'h030303, 1'b0, 19'd0, 36'h0C30C0000};

        // ---- reset state ----
        reset     = 1'b1;
        mem_grant = 1'b0;
        drive(1'b0, 1'b0, 24'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",  64'(mem_req),  64'd0);
        check("rst_we",   64'(mem_we),   64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_data", 64'(mem_data), 64'd0);
        check("rst_ovf",  64'(overflow), 64'd0);
        next_cycle();
        reset = 1'b0;

        // ---- basic write: pixels in cycles 0,1, write strobe in cycle 12 ----
        mem_grant = 1'b1;
        exp_q.push_back({19'd0, 36'hFFFFC1041});
        for (int k = 0; k < 16; k++) begin
            if (k == 0)      drive(1'b1, 1'b1, 24'hFFFFFF);
            else if (k == 1) drive(1'b1, 1'b0, 24'h040404);
            else             drive(1'b0, 1'b0, 24'h0);
            @(negedge clk);
            check("basic_req", 64'(mem_req), (k == 11 || k == 12) ? 64'd1 : 64'd0);
            check("basic_we",  64'(mem_we),  (k == 12) ? 64'd1 : 64'd0);
            next_cycle();
        end
        drain("basic", 20);

        // ---- table: back-to-back pairs, address wrap at FRAME_WORDS ----
        for (int i = 0; i < 5; i++) exp_q.push_back({vecs[i].exp_addr, vecs[i].exp_data});
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, vecs[i].sof, vecs[i].rgb_a);
            next_cycle();
            drive(1'b1, 1'b0, vecs[i].rgb_b);
            next_cycle();
        end
        drive(1'b0, 1'b0, 24'h0);
        drain("table", 60);

        // ---- mid-frame SOF: third pixel discarded ----
        exp_q.push_back({19'd0, 36'hFFFFC0000});
        exp_q.push_back({19'd0, 36'hAB3EE0000});
        drive(1'b1, 1'b1, 24'hFFFFFF); next_cycle();
        drive(1'b1, 1'b0, 24'h000000); next_cycle();
        drive(1'b1, 1'b0, 24'h123456); next_cycle();
        drive(1'b1, 1'b1, 24'hABCDEF); next_cycle();
        drive(1'b1, 1'b0, 24'h800000); next_cycle();
        drive(1'b0, 1'b0, 24'h0);
        drain("midsof", 40);

        // ---- overflow: six words with grant held low ----
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back({19'(i), gword(2 * i)});
        for (int k = 0; k < 30; k++) begin
            if (k < 12) drive(1'b1, k == 0, gray(k));
            else        drive(1'b0, 1'b0, 24'h0);
            mem_grant = (k >= 25);
            @(negedge clk);
            if (k == 17) check("ovf_after_4", 64'(overflow), 64'd0);
            if (k == 18) check("ovf_after_5", 64'(overflow), 64'd1);
            if (k == 24) check("ovf_req_held", 64'(mem_req), 64'd1);
            next_cycle();
        end
        drain("overflow", 40);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // ---- reset asserted during WRITE ----
        mem_grant = 1'b1;
        exp_q.push_back({19'd0, gword(20)});
        for (int k = 0; k < 16; k++) begin
            if (k < 6) drive(1'b1, k == 0, gray(20 + k));
            else       drive(1'b0, 1'b0, 24'h0);
            reset = (k == 12);
            @(negedge clk);
            if (k == 12) check("rstw_in_write", 64'(mem_we), 64'd1);
            if (k == 13) begin
                check("rstw_we",   64'(mem_we),   64'd0);
                check("rstw_req",  64'(mem_req),  64'd0);
                check("rstw_ovf",  64'(overflow), 64'd0);
                check("rstw_addr", 64'(mem_addr), 64'd0);
                check("rstw_data", 64'(mem_data), 64'd0);
            end
            next_cycle();
        end
        reset = 1'b0;
        repeat (20) next_cycle();
        drain("rstw_flush", 1);
        exp_q.push_back({19'd0, gword(30)});
        drive(1'b1, 1'b1, gray(30)); next_cycle();
        drive(1'b1, 1'b0, gray(31)); next_cycle();
        drive(1'b0, 1'b0, 24'h0);
        drain("rstw_after", 30);

        // ---- push and pop in the same cycle while full ----
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back({19'(i % 4), gword(2 * i)});
        for (int k = 0; k < 25; k++) begin
            if (k < 10) drive(1'b1, k == 0, gray(k));
            else        drive(1'b0, 1'b0, 24'h0);
            mem_grant = (k >= 17);
            @(negedge clk);
            if (k == 16) check("pp_req_wait", 64'(mem_req), 64'd1);
            if (k == 18) check("pp_first_we", 64'(mem_we), 64'd1);
            if (k == 18) check("pp_no_drop", 64'(overflow), 64'd0);
            next_cycle();
        end
        drain("pushpop", 40);
        check("pp_ovf_end", 64'(overflow), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
